// File: rtl/i2c_target_regfile_if.sv
// -----------------------------------------------------------------------------
// i2c_target_regfile_if
//   Fabric-side port of the I2C target register file: the write-notify event
//   (strobe + index + byte) and the local read port.
//
//   wr_strobe   one-cycle pulse per committed I2C register write
//   wr_addr     register index of the committed write
//   wr_data     byte written
//   local_addr  local read index (driven by the fabric)
//   local_data  register[local_addr], registered, 1-cycle latency
//
//   modport master : fabric side (issues local_addr, observes the rest)
//   modport slave  : register file side
// -----------------------------------------------------------------------------
interface i2c_target_regfile_if;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] local_addr;
    logic [7:0] local_data;

    modport master (
        input  wr_strobe,
        input  wr_addr,
        input  wr_data,
        input  local_data,
        output local_addr
    );

    modport slave (
        output wr_strobe,
        output wr_addr,
        output wr_data,
        output local_data,
        input  local_addr
    );
endinterface

// File: rtl/i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// i2c_target_regfile
//   I2C target holding a 256 x 8 register file behind a 7-bit device address,
//   with an 8-bit sub-address pointer that auto-increments (wrapping 0xFF->0x00)
//   on every written byte and every ACKed read byte. The pointer persists
//   across transactions. SCL is never stretched.
//
//   clock_50          system clock (SCL phases must each last >= 8 cycles)
//   reset             asynchronous, active-low
//   i2c_serial_clock  SCL from the initiator
//   i2c_serial_data   SDA, open-drain: driven 0 or released (high-Z)
//   busy              high from an address-matched START until STOP / NACK
//   fab               fabric port: write-notify strobe and local read port
// -----------------------------------------------------------------------------
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR    = 7'h39,
    parameter int unsigned SYNC_STAGES = 2      // must be >= 2
) (
    input  logic                 clock_50,
    input  logic                 reset,
    input  logic                 i2c_serial_clock,
    inout  wire                  i2c_serial_data,
    output logic                 busy,
    i2c_target_regfile_if.slave  fab
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_SUBADDR,
        S_SUBADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    state_t     r_state;
    logic [3:0] r_bit_cnt;     // bits shifted in (or out) of the current byte
    logic [7:0] r_shift;
    logic       r_rw;          // R/W bit of the matched address byte
    logic       r_nack;        // initiator's answer sampled in READ_ACK
    logic [7:0] r_ptr;
    logic       r_sda_low;     // 1 = pull SDA low, 0 = release
    logic       r_busy;
    logic       r_wr_strobe;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_local_data;
    logic [7:0] r_mem [256];

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_ptr_byte;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl &  r_scl_prev;
    // START/STOP only count while SCL has been high on both samples, so an SDA
    // change made by the initiator during SCL low is never misread as either.
    assign w_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;
    assign w_ptr_byte = r_mem[r_ptr];

    assign i2c_serial_data = r_sda_low ? 1'b0 : 1'bz;
    assign busy            = r_busy;
    assign fab.wr_strobe   = r_wr_strobe;
    assign fab.wr_addr     = r_wr_addr;
    assign fab.wr_data     = r_wr_data;
    assign fab.local_data  = r_local_data;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_scl_sync   <= '1;
            r_sda_sync   <= '1;
            r_scl_prev   <= 1'b1;
            r_sda_prev   <= 1'b1;
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rw         <= 1'b0;
            r_nack       <= 1'b0;
            r_ptr        <= '0;
            r_sda_low    <= 1'b0;
            r_busy       <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_local_data <= '0;
            // NOTE: the register file must power up as all-zero, so it is built
            // from resettable flops rather than a RAM macro, which cannot be reset.
            for (int i = 0; i < 256; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every right-hand side below
            // read the pre-edge value, which is what gives the local read port
            // the old byte when an I2C write hits the same index this cycle.
            r_scl_sync   <= {r_scl_sync[SYNC_STAGES-2:0], i2c_serial_clock};
            r_sda_sync   <= {r_sda_sync[SYNC_STAGES-2:0], i2c_serial_data};
            r_scl_prev   <= w_scl;
            r_sda_prev   <= w_sda;
            r_wr_strobe  <= 1'b0;
            r_local_data <= r_mem[fab.local_addr];

            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= '0;
                r_sda_low <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    S_ADDR, S_SUBADDR, S_WRITE: begin
                        if (r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_READ_ACK: begin
                        r_nack <= w_sda;
                        if (!w_sda) begin
                            r_ptr <= r_ptr + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    S_ADDR: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= '0;
                            if (r_shift[7:1] == DEV_ADDR) begin
                                r_rw      <= r_shift[0];
                                r_sda_low <= 1'b1;
                                r_busy    <= 1'b1;
                                r_state   <= S_ADDR_ACK;
                            end else begin
                                r_sda_low <= 1'b0;
                                r_busy    <= 1'b0;
                                r_state   <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (r_rw) begin
                            r_shift   <= w_ptr_byte;
                            r_sda_low <= ~w_ptr_byte[7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_READ;
                        end else begin
                            r_sda_low <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= S_SUBADDR;
                        end
                    end
                    S_SUBADDR: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_ptr     <= r_shift;
                            r_sda_low <= 1'b1;
                            r_state   <= S_SUBADDR_ACK;
                        end
                    end
                    S_WRITE: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_mem[r_ptr] <= r_shift;
                            r_wr_strobe  <= 1'b1;
                            r_wr_addr    <= r_ptr;
                            r_wr_data    <= r_shift;
                            r_ptr        <= r_ptr + 8'd1;
                            r_sda_low    <= 1'b1;
                            r_state      <= S_WRITE_ACK;
                        end
                    end
                    S_SUBADDR_ACK, S_WRITE_ACK: begin
                        r_sda_low <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_WRITE;
                    end
                    S_READ: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_sda_low <= 1'b0;
                            r_state   <= S_READ_ACK;
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_sda_low <= ~r_shift[6];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_READ_ACK: begin
                        if (r_nack) begin
                            r_sda_low <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            // r_ptr already advanced on the ACK rising edge.
                            r_shift   <= w_ptr_byte;
                            r_sda_low <= ~w_ptr_byte[7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_READ;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regfile
//   Bit-banged I2C initiator driving i2c_target_regfile. A transaction-level
//   model (256-byte array, pointer, queue of expected write events) predicts
//   every ACK, read byte and write-notify event; a per-cycle monitor compares
//   the fabric port against it. Directed cases pin literal values, then
//   randomized transactions run against the model.
// -----------------------------------------------------------------------------
module tb_i2c_target_regfile;

    localparam int Q = 5;   // SCL-low quarter (SDA changes after Q, rises after 2Q)
    localparam int H = 8;   // SCL-high duration in clock_50 cycles

    logic clock_50   = 1'b0;
    logic reset      = 1'b0;
    logic scl        = 1'b1;
    logic tb_sda_low = 1'b0;
    logic busy;
    wire  i2c_sda;

    assign i2c_sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    i2c_target_regfile_if fab ();

    i2c_target_regfile #(.DEV_ADDR(7'h39), .SYNC_STAGES(2)) dut (
        .clock_50         (clock_50),
        .reset            (reset),
        .i2c_serial_clock (scl),
        .i2c_serial_data  (i2c_sda),
        .busy             (busy),
        .fab              (fab)
    );

    always #10 clock_50 = ~clock_50;

    // ---------------- model state ----------------
    logic [7:0]  m_mem [256];
    logic [7:0]  m_ptr = 8'h00;
    logic [15:0] exp_q [$];
    logic [15:0] act_log [$];
    logic [7:0]  txd [4];
    logic [7:0]  rxd [4];
    int          n_total = 0;
    int          n_bad   = 0;
    logic        quiet     = 1'b0;
    logic        watch     = 1'b0;
    logic        sda_viol  = 1'b0;
    logic        busy_viol = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle monitor ----------------
    initial begin
        logic [7:0]  addr_q   = 8'h00;
        logic        quiet_q  = 1'b0;
        logic        strobe_q = 1'b0;
        logic [15:0] e;
        forever begin
            @(negedge clock_50);
            if (!reset) begin
                quiet_q  = 1'b0;
                strobe_q = 1'b0;
            end else begin
                if (fab.wr_strobe) begin
                    check("strobe_not_back_to_back", strobe_q, 1'b0);
                    check("strobe_expected", exp_q.size() > 0, 1'b1);
                    act_log.push_back({fab.wr_addr, fab.wr_data});
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("wr_event", {fab.wr_addr, fab.wr_data}, e);
                    end
                end
                strobe_q = fab.wr_strobe;
                if (quiet && quiet_q) begin
                    check("local_data", fab.local_data, m_mem[addr_q]);
                end
                if (watch) begin
                    if (!tb_sda_low && i2c_sda !== 1'b1) sda_viol = 1'b1;
                    if (busy) busy_viol = 1'b1;
                end
                addr_q  = fab.local_addr;
                quiet_q = quiet;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clock_50);
        $display("FAIL watchdog: run did not finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bus primitives ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock_50);
        #3;
    endtask

    task automatic bus_start();
        wait_clk(Q); tb_sda_low = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(H); tb_sda_low = 1'b1;
        wait_clk(H); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); tb_sda_low = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(H); tb_sda_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        wait_clk(Q); tb_sda_low = ~b;
        wait_clk(Q); scl = 1'b1;
        wait_clk(H); s = i2c_sda; scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~give_ack, s);
    endtask

    task automatic settle();
        wait_clk(4);
        check("busy_idle", busy, 1'b0);
        check("wr_events_drained", 32'(exp_q.size()), 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fab.local_addr = 8'($urandom);
            wait_clk(1);
        end
    endtask

    // ---------------- transactions (model updated alongside) ----------------
    task automatic addr_and_sub(input logic [7:0] sub);
        logic ack;
        write_byte(8'h72, ack); check("addr_w_ack", ack, 1'b1);
        write_byte(sub, ack);   check("sub_ack", ack, 1'b1);
        m_ptr = sub;
    endtask

    task automatic wr_txn(input logic [7:0] sub, input int n);
        logic ack;
        quiet = 1'b0;
        bus_start();
        addr_and_sub(sub);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({m_ptr, txd[i]});
            m_mem[m_ptr] = txd[i];
            m_ptr = m_ptr + 8'd1;
            write_byte(txd[i], ack); check("data_ack", ack, 1'b1);
        end
        bus_stop();
        settle();
    endtask

    task automatic rd_txn(input logic with_sub, input logic [7:0] sub, input int n);
        logic ack;
        logic [7:0] d;
        quiet = 1'b0;
        bus_start();
        if (with_sub) begin
            addr_and_sub(sub);
            bus_start();
        end
        write_byte(8'h73, ack); check("addr_r_ack", ack, 1'b1);
        check("busy_in_read", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d);
            rxd[i] = d;
            check("read_data", d, m_mem[m_ptr]);
            if (i < n - 1) m_ptr = m_ptr + 8'd1;
        end
        wait_clk(Q);
        check("busy_after_nack", busy, 1'b0);
        bus_stop();
        settle();
    endtask

    task automatic miss_txn(input logic [7:0] a0, input logic [7:0] a1);
        logic ack;
        quiet = 1'b0; watch = 1'b1; sda_viol = 1'b0; busy_viol = 1'b0;
        bus_start();
        write_byte(a0, ack); check("miss_no_ack_addr", ack, 1'b0);
        write_byte(a1, ack); check("miss_no_ack_next", ack, 1'b0);
        bus_stop();
        watch = 1'b0;
        check("miss_sda_never_driven", sda_viol, 1'b0);
        check("miss_busy_stays_low", busy_viol, 1'b0);
        settle();
    endtask

    task automatic abort_txn(input logic [7:0] sub, input int nfull, input logic [7:0] part, input int k);
        logic ack;
        logic s;
        quiet = 1'b0;
        bus_start();
        addr_and_sub(sub);
        for (int i = 0; i < nfull; i++) begin
            exp_q.push_back({m_ptr, txd[i]});
            m_mem[m_ptr] = txd[i];
            m_ptr = m_ptr + 8'd1;
            write_byte(txd[i], ack); check("data_ack", ack, 1'b1);
        end
        for (int i = 0; i < k; i++) bus_bit(part[7-i], s);
        bus_stop();
        settle();
    endtask

    task automatic local_read(input logic [7:0] a, input logic [7:0] exp, input string name);
        fab.local_addr = a;
        wait_clk(1);
        check(name, fab.local_data, exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int kind;
        int n;
        logic [6:0] a7;

        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        fab.local_addr = 8'h00;
        wait_clk(4);
        check("reset_busy", busy, 1'b0);
        check("reset_strobe", fab.wr_strobe, 1'b0);
        check("reset_local_data", fab.local_data, 8'h00);
        check("reset_sda_released", i2c_sda, 1'b1);
        reset = 1'b1;
        wait_clk(4);

        // Write 0x10,0x20 at 0x41
        act_log.delete();
        txd[0] = 8'h10; txd[1] = 8'h20;
        wr_txn(8'h41, 2);
        check("write_log_len", 32'(act_log.size()), 32'd2);
        check("write_ev0", act_log[0], 16'h4110);
        check("write_ev1", act_log[1], 16'h4220);
        local_read(8'h42, 8'h20, "local_0x42");

        // Combined read from 0x41
        rd_txn(1'b1, 8'h41, 2);
        check("read_byte0", rxd[0], 8'h10);
        check("read_byte1", rxd[1], 8'h20);

        // Address mismatch
        miss_txn(8'h74, 8'hAA);

        // Pointer wrap
        act_log.delete();
        txd[0] = 8'h5A; txd[1] = 8'hA5;
        wr_txn(8'hFF, 2);
        check("wrap_ev0", act_log[0], 16'hFF5A);
        check("wrap_ev1", act_log[1], 16'h00A5);
        local_read(8'hFF, 8'h5A, "local_0xff");
        local_read(8'h00, 8'hA5, "local_0x00");

        // Abort after 4 bits of a data byte, then a normal write
        act_log.delete();
        abort_txn(8'h20, 0, 8'hC3, 4);
        check("abort_no_strobe", 32'(act_log.size()), 32'd0);
        txd[0] = 8'h33;
        wr_txn(8'h10, 1);
        check("after_abort_ev", act_log[0], 16'h1033);
        local_read(8'h10, 8'h33, "local_0x10");

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 4);
            n    = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
            case (kind)
                0: wr_txn(8'($urandom), n);
                1: rd_txn(1'b1, 8'($urandom), n);
                2: rd_txn(1'b0, 8'h00, n);
                3: begin
                    a7 = 7'($urandom);
                    if (a7 == 7'h39) a7 = 7'h3A;
                    miss_txn({a7, 1'($urandom)}, 8'($urandom));
                end
                default: abort_txn(8'($urandom), $urandom_range(0, 2), 8'($urandom), $urandom_range(1, 7));
            endcase
        end

        // Reset while the target drives SDA low during a read
        txd[0] = 8'h10;
        wr_txn(8'h41, 1);
        quiet = 1'b0;
        bus_start();
        addr_and_sub(8'h41);
        bus_start();
        begin
            logic ack;
            write_byte(8'h73, ack); check("rst_addr_r_ack", ack, 1'b1);
        end
        wait_clk(Q);
        check("rst_target_drives_low", i2c_sda, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_sda_released_async", i2c_sda, 1'b1);
        check("rst_busy_cleared", busy, 1'b0);
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_ptr = 8'h00;
        exp_q.delete();
        wait_clk(3);
        scl = 1'b1;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(3);
        local_read(8'h41, 8'h00, "rst_reg41_cleared");
        rd_txn(1'b1, 8'h41, 1);
        check("rst_i2c_read_0x41", rxd[0], 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (responder) holding a 256 x 8 register file behind a 7-bit device address, with 8-bit sub-address and auto-increment.
- Sits on the board I2C bus opposite the HDMI transmitter's configuration initiator.
- Lets the bench or a loop-back build close the configuration path without the external transmitter chip.
- Exposes a write-notify strobe and a local read port to the rest of the fabric.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address (write/read bytes 0x72/0x73).
- SYNC_STAGES, 2, synchronizer depth on SCL/SDA, minimum 2.

Ports:
- clock_50  input  1  system clock; SCL high/low phases must each be at least 8 clock_50 cycles.
- reset  input  1  asynchronous, active-low.
- i2c_serial_clock  input  1  SCL from the initiator; the target never stretches the clock.
- i2c_serial_data  inout  1  SDA, open-drain; only ever driven 0 or high-Z.
- wr_strobe  output  1  one-cycle pulse per committed register write.
- wr_addr  output  8  register index of the committed write.
- wr_data  output  8  byte written.
- local_addr  input  8  local read index.
- local_data  output  8  register[local_addr], registered, 1-cycle latency.
- busy  output  1  high from an address-matched START until STOP or NACK-return-to-IDLE.

Behaviour:
- Reset (reset=0, async) clears:
  - all register contents to 0x00; pointer to 0x00;
  - state to IDLE; SDA released (high-Z);
  - wr_strobe, wr_addr, wr_data, local_data, busy to 0;
  - synchronizers preset to 1.
- Reset mid-transaction releases SDA immediately; the bus transaction is abandoned.
- SCL/SDA pass through SYNC_STAGES flops; edges are detected on the synchronized values.
- SCL rising edge: sample SDA.
- SCL falling edge: change the driven SDA value.
- START = SDA falling while SCL high. Accepted in any state, including repeated start: clear bit counter, go to ADDR.
- STOP = SDA rising while SCL high. Accepted in any state: release SDA, go to IDLE, busy=0.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits MSB-first. On the 8th falling edge:
    - bits[7:1]==DEV_ADDR: drive SDA=0 (ACK) and go to ADDR_ACK; busy=1.
    - otherwise: release SDA and go to IDLE (no ACK).
  - ADDR_ACK: on the next falling edge release SDA.
    - R/W=0: go to SUBADDR.
    - R/W=1: load shift register with register[pointer], drive its MSB (0 -> drive low, 1 -> release), go to READ.
  - SUBADDR: shift 8 bits; the 8th falling edge loads pointer and drives ACK -> SUBADDR_ACK. The next falling edge releases SDA -> WRITE.
  - WRITE: shift 8 bits. On the 8th falling edge:
    - write register[pointer];
    - pulse wr_strobe with wr_addr=pointer, wr_data=byte;
    - pointer+1 (0xFF wraps to 0x00);
    - drive ACK -> WRITE_ACK. The next falling edge releases SDA -> WRITE.
  - READ: drive the next bit on each falling edge; release SDA after the 8th bit -> READ_ACK.
  - READ_ACK: sample SDA on the rising edge.
    - 0 (ACK): pointer+1 with wrap; on the falling edge load register[pointer] and drive its MSB -> READ.
    - 1 (NACK): go to IDLE on the falling edge, busy=0, pointer holds.
- START/STOP mid-byte discards partial bits; no register is written.
- A write transaction of only the sub-address sets the pointer; a following repeated-start read begins there.
- The pointer persists across transactions.
- Local read vs. I2C write to the same index in the same cycle: local_data returns the old value.
- wr_strobe is never asserted on two consecutive cycles.

Test Plan:
- Write: START, 0x72, sub 0x41, data 0x10 0x20, STOP -> ACK on all four bytes; wr_strobe pulses (0x41,0x10) then (0x42,0x20); local_addr=0x42 gives local_data=0x20 after 1 cycle.
- Combined read: START 0x72, sub 0x41, repeated START 0x73, read 2 bytes (ACK, NACK), STOP -> SDA returns 0x10, 0x20; busy falls after NACK.
- Address mismatch: START 0x74, 0xAA -> no ACK on any bit; no wr_strobe; SDA never driven; busy stays 0.
- Wrap: write sub 0xFF, data 0x5A 0xA5 -> register[0xFF]=0x5A, register[0x00]=0xA5, wr_addr sequence 0xFF, 0x00.
- Abort: STOP after 4 bits of a data byte -> no wr_strobe; state IDLE; next transaction (write 0x33 to 0x10) behaves normally.
- Reset mid-read: assert reset while the target drives SDA low -> SDA high-Z asynchronously; register[0x41] reads back 0x00 afterwards.
